sm4_ck_stream: RTL and testbench

Parametrised SM4 CK round-constant generator. It replaces the fixed 32-entry lookup table with on-the-fly arithmetic, using the rule CK byte k of round i = ((4*i+k)*STEP) mod 256. It streams the round constants to the key-expansion datapath over a valid/ready handshake, in forward order (encryption schedule) or reverse order (decryption schedule). It sits between the top-level control FSM, which issues start, and the key-expansion round logic, which consumes the constants.

---
 rtl/sm4_ck_stream.sv | 113 +++++++++++
 tb/tb_sm4_ck_stream.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sm4_ck_stream.sv
// SM4 CK round-constant streamer: generates CK words arithmetically instead of
// from a table and hands them out over valid/ready, forward or reverse order.
module sm4_ck_stream #(
  parameter int ROUNDS = 32,
  parameter int STEP   = 7,
  parameter int CNT_W  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_in,
  input  logic             reverse_in,
  input  logic             ck_ready_in,
  output logic             ck_valid_out,
  output logic [31:0]      ck_out,
  output logic [CNT_W-1:0] round_out,
  output logic             last_out,
  output logic             busy_out,
  output logic             done_out
);

  localparam logic [7:0] STEP1 = 8'(STEP);
  localparam logic [7:0] STEP2 = 8'(2 * STEP);
  localparam logic [7:0] STEP3 = 8'(3 * STEP);
  localparam logic [7:0] STEP4 = 8'(4 * STEP);
  localparam logic [7:0] REV_BASE = 8'(((ROUNDS - 1) * 4 * STEP) % 256);
  localparam logic [CNT_W-1:0] LAST_FWD = CNT_W'(ROUNDS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] round_reg, round_next;
  logic [7:0]       base_reg, base_next;
  logic             dir_reg, dir_next;
  logic [31:0]      ck_reg, ck_next;
  logic             done_reg, done_next;

  logic             fire;
  logic             at_last;
  logic [7:0]       adv_base;
  logic [7:0]       start_base;

  // Byte k of the word is base + k*STEP, all wrapping mod 256.
  function automatic logic [31:0] ck_word(input logic [7:0] b);
    ck_word = {b, 8'(b + STEP1), 8'(b + STEP2), 8'(b + STEP3)};
  endfunction

  assign at_last    = dir_reg ? (round_reg == '0) : (round_reg == LAST_FWD);
  assign fire       = (state_reg == RUN) && ck_ready_in;
  assign adv_base   = dir_reg ? 8'(base_reg - STEP4) : 8'(base_reg + STEP4);
  assign start_base = reverse_in ? REV_BASE : 8'h00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      round_reg <= '0;
      base_reg  <= 8'h00;
      dir_reg   <= 1'b0;
      ck_reg    <= 32'h0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      round_reg <= round_next;
      base_reg  <= base_next;
      dir_reg   <= dir_next;
      ck_reg    <= ck_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    round_next = round_reg;
    base_next  = base_reg;
    dir_next   = dir_reg;
    ck_next    = ck_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start_in) begin
          state_next = RUN;
          dir_next   = reverse_in;
          round_next = reverse_in ? LAST_FWD : '0;
          base_next  = start_base;
          ck_next    = ck_word(start_base);
        end
      end
      RUN: begin
        if (fire) begin
          if (at_last) begin
            // ck/round keep their final values once the stream ends.
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            round_next = dir_reg ? round_reg - CNT_W'(1) : round_reg + CNT_W'(1);
            base_next  = adv_base;
            ck_next    = ck_word(adv_base);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ck_valid_out = (state_reg == RUN);
    busy_out     = (state_reg == RUN);
    last_out     = (state_reg == RUN) && at_last;
    ck_out       = ck_reg;
    round_out    = round_reg;
    done_out     = done_reg;
  end

endmodule

// File: tb/tb_sm4_ck_stream.sv
// Scoreboard bench for sm4_ck_stream: stimulus queues expected words, a
// negedge monitor pops and checks each accepted word.
module tb_sm4_ck_stream;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_in = 1'b0, reverse_in = 1'b0, ck_ready_in = 1'b1;
  logic        ck_valid_out, last_out, busy_out, done_out;
  logic [31:0] ck_out;
  logic [4:0]  round_out;

  logic        start8 = 1'b0, rev8 = 1'b0, ready8 = 1'b1;
  logic        valid8, last8, busy8, done8;
  logic [31:0] ck8;
  logic [2:0]  round8;

  always #5 clk = ~clk;

  sm4_ck_stream #(.ROUNDS(32), .STEP(7), .CNT_W(5)) u_dut (
    .clk(clk), .rst_n(rst_n), .start_in(start_in), .reverse_in(reverse_in),
    .ck_ready_in(ck_ready_in), .ck_valid_out(ck_valid_out), .ck_out(ck_out),
    .round_out(round_out), .last_out(last_out), .busy_out(busy_out),
    .done_out(done_out));

  sm4_ck_stream #(.ROUNDS(8), .STEP(7), .CNT_W(3)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start_in(start8), .reverse_in(rev8),
    .ck_ready_in(ready8), .ck_valid_out(valid8), .ck_out(ck8),
    .round_out(round8), .last_out(last8), .busy_out(busy8),
    .done_out(done8));

  typedef struct {
    logic [31:0] ck;
    logic [4:0]  rnd;
    logic        last;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int fails = 0;
  int fires = 0;

  // Hand-computed reference words for ROUNDS=32, STEP=7.
  int          hand_r[7] = '{0, 5, 6, 9, 12, 30, 31};
  logic [31:0] hand_v[7] = '{32'h00070e15, 32'h8c939aa1, 32'ha8afb6bd, 32'hfc030a11,
                             32'h50575e65, 32'h484f565d, 32'h646b7279};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Closed-form reference: byte k of round i is (4*i+k)*7 mod 256.
  function automatic logic [31:0] exp_ck(input int i);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[31-8*k -: 8] = 8'(((4 * i + k) * 7) % 256);
    return w;
  endfunction

  always @(negedge clk) begin
    if (rst_n && ck_valid_out && ck_ready_in) begin
      exp_t e;
      fires++;
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL sb_underflow: got word %h round %0d, expected none", ck_out, round_out);
      end else begin
        e = sb.pop_front();
        $display("word round=%0d ck=%h last=%0b", round_out, ck_out, last_out);
        chk("ck", ck_out, e.ck);
        chk("round", 32'(round_out), 32'(e.rnd));
        chk("last", 32'(last_out), 32'(e.last));
      end
      for (int h = 0; h < 7; h++)
        if (32'(round_out) == hand_r[h]) chk("ck_hand", ck_out, hand_v[h]);
    end
  end

  task automatic push_stream(input bit rev);
    for (int k = 0; k < 32; k++) begin
      exp_t e;
      int i;
      i = rev ? 31 - k : k;
      e.ck = exp_ck(i);
      e.rnd = 5'(i);
      e.last = (k == 31);
      sb.push_back(e);
    end
  endtask

  task automatic kick(input bit rev);
    push_stream(rev);
    @(posedge clk); #1;
    start_in = 1'b1;
    reverse_in = rev;
    chk("idle_valid", 32'(ck_valid_out), 32'd0);
    @(posedge clk); #1;
    start_in = 1'b0;
    reverse_in = 1'b0;
    chk("lat_valid", 32'(ck_valid_out), 32'd1);
    chk("lat_busy", 32'(busy_out), 32'd1);
    chk("lat_ck", ck_out, rev ? 32'h646b7279 : 32'h00070e15);
  endtask

  task automatic wait_round(input int r);
    for (int k = 0; k < 200; k++) begin
      if (ck_valid_out && 32'(round_out) == r) return;
      @(posedge clk); #1;
    end
    chk("wait_round_timeout", 32'(round_out), 32'(r));
  endtask

  task automatic finish_stream(input int exp_cycles, input int fires_before);
    int n;
    bit seen;
    seen = 1'b0;
    n = 0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(posedge clk); #1;
      n++;
      if (done_out) seen = 1'b1;
    end
    chk("done_seen", 32'(seen), 32'd1);
    if (exp_cycles >= 0) chk("stream_cycles", 32'(n), 32'(exp_cycles));
    chk("word_count", 32'(fires - fires_before), 32'd32);
    chk("end_valid", 32'(ck_valid_out), 32'd0);
    chk("end_busy", 32'(busy_out), 32'd0);
    chk("end_last", 32'(last_out), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    @(posedge clk); #1;
    chk("done_pulse", 32'(done_out), 32'd0);
  endtask

  task automatic wait_last8();
    for (int k = 0; k < 50; k++) begin
      if (valid8 && last8) return;
      @(posedge clk); #1;
    end
    chk("wait_last8_timeout", 32'(last8), 32'd1);
  endtask

  initial begin
    int f0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(ck_valid_out), 32'd0);
    chk("rst_ck", ck_out, 32'h0);
    chk("rst_round", 32'(round_out), 32'd0);
    chk("rst_flags", {29'd0, last_out, busy_out, done_out}, 32'd0);
    rst_n = 1'b1;

    // Forward, ready tied high: 32 back-to-back words.
    f0 = fires;
    kick(1'b0);
    finish_stream(32, f0);

    // Reverse order.
    f0 = fires;
    kick(1'b1);
    finish_stream(32, f0);

    // Backpressure on round 5.
    f0 = fires;
    kick(1'b0);
    wait_round(5);
    ck_ready_in = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("bp_ck", ck_out, 32'h8c939aa1);
      chk("bp_valid", 32'(ck_valid_out), 32'd1);
      chk("bp_round", 32'(round_out), 32'd5);
    end
    ck_ready_in = 1'b1;
    @(posedge clk); #1;
    chk("bp_release", ck_out, 32'ha8afb6bd);
    finish_stream(-1, f0);

    // Start while busy is ignored.
    f0 = fires;
    kick(1'b0);
    wait_round(12);
    chk("busy_r12", ck_out, 32'h50575e65);
    start_in = 1'b1;
    reverse_in = 1'b1;
    @(posedge clk); #1;
    start_in = 1'b0;
    reverse_in = 1'b0;
    chk("busy_r13", ck_out, 32'h6c737a81);
    chk("busy_round", 32'(round_out), 32'd13);
    finish_stream(-1, f0);

    // Asynchronous reset mid-stream.
    kick(1'b0);
    wait_round(10);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(ck_valid_out), 32'd0);
    chk("arst_ck", ck_out, 32'h0);
    chk("arst_round", 32'(round_out), 32'd0);
    chk("arst_flags", {29'd0, last_out, busy_out, done_out}, 32'd0);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("arst_nodone", 32'(done_out), 32'd0);
    chk("arst_idle", 32'(busy_out), 32'd0);
    f0 = fires;
    kick(1'b0);
    finish_stream(32, f0);

    // ROUNDS=8 variant.
    @(posedge clk); #1;
    start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    chk("r8_first", ck8, 32'h00070e15);
    wait_last8();
    chk("r8_fwd_last", ck8, 32'hc4cbd2d9);
    chk("r8_fwd_round", 32'(round8), 32'd7);
    @(posedge clk); #1;
    chk("r8_done", 32'(done8), 32'd1);
    start8 = 1'b1;
    rev8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    rev8 = 1'b0;
    chk("r8_rev_first", ck8, 32'hc4cbd2d9);
    chk("r8_rev_round", 32'(round8), 32'd7);
    chk("r8_rev_notlast", 32'(last8), 32'd0);
    wait_last8();
    chk("r8_rev_last", ck8, 32'h00070e15);
    chk("r8_rev_round0", 32'(round8), 32'd0);
    @(posedge clk); #1;
    chk("r8_rev_done", 32'(done8), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
